// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor and controller: lamp codes,
// phase/error encodings, monitor states and small decode helpers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;

    typedef enum logic [1:0] {
        PHASE_RED    = 2'b00,
        PHASE_GREEN  = 2'b01,
        PHASE_YELLOW = 2'b10,
        PHASE_NONE   = 2'b11
    } phase_e;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_ILLEGAL_CODE  = 3'd1,
        ERR_ILLEGAL_TRANS = 3'd2,
        ERR_DWELL_SHORT   = 3'd3,
        ERR_DWELL_LONG    = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IN_RED,
        ST_IN_GREEN,
        ST_IN_YELLOW,
        ST_FAULT
    } mon_state_e;

    function automatic logic isLegalLight(input logic [2:0] light);
        return (light == LIGHT_RED) || (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
    endfunction

    // Lamp code that keeps a tracking state where it is.
    function automatic logic [2:0] stateLight(input mon_state_e state);
        case (state)
            ST_IN_RED:    return LIGHT_RED;
            ST_IN_GREEN:  return LIGHT_GREEN;
            ST_IN_YELLOW: return LIGHT_YELLOW;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] successorLight(input mon_state_e state);
        case (state)
            ST_IN_RED:    return LIGHT_GREEN;
            ST_IN_GREEN:  return LIGHT_YELLOW;
            ST_IN_YELLOW: return LIGHT_RED;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic mon_state_e successorState(input mon_state_e state);
        case (state)
            ST_IN_RED:    return ST_IN_GREEN;
            ST_IN_GREEN:  return ST_IN_YELLOW;
            ST_IN_YELLOW: return ST_IN_RED;
            default:      return state;
        endcase
    endfunction

    function automatic phase_e stateToPhase(input mon_state_e state);
        case (state)
            ST_IN_RED:    return PHASE_RED;
            ST_IN_GREEN:  return PHASE_GREEN;
            ST_IN_YELLOW: return PHASE_YELLOW;
            default:      return PHASE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_dwell_counter.sv
// Saturating dwell counter: clear has priority over load-to-one, which has
// priority over increment; otherwise the count holds.
module traffic_dwell_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load1_i,
    input  logic         incr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = W'(1);
        end else if (incr_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches a sampled lamp code, tracks the red-green-yellow sequence, counts
// completed cycles and latches the first fault until clr_err.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_DWELL = 1,
    parameter int unsigned MAX_DWELL = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell_cnt,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err,
    output logic [2:0]       err_code
);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycleCount_q, cycleCount_d;
    logic             err_q, err_d;
    err_code_e        errCode_q, errCode_d;

    logic             dwellClear;
    logic             dwellLoad1;
    logic             dwellIncr;
    logic [CNT_W-1:0] dwellCnt;
    err_code_e        faultCode;
    logic [2:0]       curLight;
    logic [2:0]       nextLight;
    logic             dwellAtMax;
    logic             dwellTooShort;

    assign curLight  = stateLight(state_q);
    assign nextLight = successorLight(state_q);

    // Compared at 32 bits so a small CNT_W can never alias onto the limits.
    assign dwellAtMax    = 32'(dwellCnt) >= MAX_DWELL;
    assign dwellTooShort = 32'(dwellCnt) <  MIN_DWELL;

    traffic_dwell_counter #(
        .W(CNT_W)
    ) u_dwell (
        .clk     (clk),
        .reset   (reset),
        .clear_i (dwellClear),
        .load1_i (dwellLoad1),
        .incr_i  (dwellIncr),
        .count_o (dwellCnt)
    );

    // Fault causes are tested in priority order; a fault freezes the counters
    // by simply not asserting any counter command.
    always_comb begin
        state_d      = state_q;
        cycleCount_d = cycleCount_q;
        err_d        = err_q;
        errCode_d    = errCode_q;
        dwellClear   = 1'b0;
        dwellLoad1   = 1'b0;
        dwellIncr    = 1'b0;
        faultCode    = ERR_NONE;

        if (clr_err) begin
            state_d    = ST_SYNC;
            err_d      = 1'b0;
            errCode_d  = ERR_NONE;
            dwellClear = 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (!isLegalLight(light)) begin
                        faultCode = ERR_ILLEGAL_CODE;
                    end else if (light == LIGHT_RED) begin
                        state_d    = ST_IN_RED;
                        dwellLoad1 = 1'b1;
                    end
                end
                ST_IN_RED, ST_IN_GREEN, ST_IN_YELLOW: begin
                    if (!isLegalLight(light)) begin
                        faultCode = ERR_ILLEGAL_CODE;
                    end else if (light == curLight) begin
                        if (dwellAtMax) begin
                            faultCode = ERR_DWELL_LONG;
                        end else begin
                            dwellIncr = 1'b1;
                        end
                    end else if (light != nextLight) begin
                        faultCode = ERR_ILLEGAL_TRANS;
                    end else if (dwellTooShort) begin
                        faultCode = ERR_DWELL_SHORT;
                    end else begin
                        state_d    = successorState(state_q);
                        dwellLoad1 = 1'b1;
                        if ((state_q == ST_IN_YELLOW) && (cycleCount_q != '1)) begin
                            cycleCount_d = cycleCount_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase

            if (faultCode != ERR_NONE) begin
                state_d   = ST_FAULT;
                err_d     = 1'b1;
                errCode_d = faultCode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            cycleCount_q <= '0;
            err_q        <= 1'b0;
            errCode_q    <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            cycleCount_q <= cycleCount_d;
            err_q        <= err_d;
            errCode_q    <= errCode_d;
        end
    end

    assign phase       = stateToPhase(state_q);
    assign dwell_cnt   = dwellCnt;
    assign cycle_count = cycleCount_q;
    assign err         = err_q;
    assign err_code    = errCode_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Drives three differently parameterised monitors with directed and random lamp
// sequences and compares them against a sequence-level reference model.
module tb_traffic_light_monitor;

    typedef struct {
        bit synced;
        bit faulted;
        int pos;
        int run;
        int cycles;
        int code;
    } model_t;

    logic       clk;
    logic       reset;
    logic [2:0] light;
    logic       clrErr;

    logic [1:0] phaseA, phaseB, phaseC;
    logic [7:0] dwellA, dwellB, cycleA, cycleB;
    logic [1:0] dwellC, cycleC;
    logic       errA, errB, errC;
    logic [2:0] codeA, codeB, codeC;

    int     checks   = 0;
    int     failures = 0;
    string  curTag   = "init";
    model_t mdl[3];
    int     minDwell[3] = '{1, 3, 1};
    int     maxDwell[3] = '{16, 4, 16};
    int     cntMax[3]   = '{255, 255, 3};
    string  dutName[3]  = '{"A", "B", "C"};

    traffic_light_monitor dutA (
        .clk(clk), .reset(reset), .light(light), .clr_err(clrErr),
        .phase(phaseA), .dwell_cnt(dwellA), .cycle_count(cycleA),
        .err(errA), .err_code(codeA)
    );

    traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(4), .CNT_W(8)) dutB (
        .clk(clk), .reset(reset), .light(light), .clr_err(clrErr),
        .phase(phaseB), .dwell_cnt(dwellB), .cycle_count(cycleB),
        .err(errB), .err_code(codeB)
    );

    traffic_light_monitor #(.CNT_W(2)) dutC (
        .clk(clk), .reset(reset), .light(light), .clr_err(clrErr),
        .phase(phaseC), .dwell_cnt(dwellC), .cycle_count(cycleC),
        .err(errC), .err_code(codeC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model thinks in positions of the red->green->yellow sequence and run
    // lengths rather than monitor states.
    function automatic model_t stepModel(model_t m, logic [2:0] lt, bit clr,
                                         int mn, int mx, int cmax);
        model_t     r = m;
        logic [2:0] seq[3] = '{3'b100, 3'b001, 3'b010};
        int         idx = -1;
        for (int k = 0; k < 3; k++) if (lt == seq[k]) idx = k;
        if (clr) begin
            r.synced = 0; r.faulted = 0; r.run = 0; r.code = 0;
            return r;
        end
        if (m.faulted) return r;
        if (idx < 0) begin
            r.faulted = 1; r.code = 1;
        end else if (!m.synced) begin
            if (idx == 0) begin r.synced = 1; r.pos = 0; r.run = 1; end
        end else if (idx == m.pos) begin
            if (m.run >= mx) begin r.faulted = 1; r.code = 4; end
            else if (m.run < cmax) r.run = m.run + 1;
        end else if (idx != (m.pos + 1) % 3) begin
            r.faulted = 1; r.code = 2;
        end else if (m.run < mn) begin
            r.faulted = 1; r.code = 3;
        end else begin
            r.pos = idx; r.run = 1;
            if (idx == 0 && m.cycles < cmax) r.cycles = m.cycles + 1;
        end
        return r;
    endfunction

    function automatic model_t freshModel();
        model_t m;
        m.synced = 0; m.faulted = 0; m.pos = 0; m.run = 0; m.cycles = 0; m.code = 0;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input int d);
        int obsPhase, obsDwell, obsCycle, obsErr, obsCode, expPhase;
        case (d)
            0: begin obsPhase = phaseA; obsDwell = dwellA; obsCycle = cycleA; obsErr = errA; obsCode = codeA; end
            1: begin obsPhase = phaseB; obsDwell = dwellB; obsCycle = cycleB; obsErr = errB; obsCode = codeB; end
            default: begin obsPhase = phaseC; obsDwell = dwellC; obsCycle = cycleC; obsErr = errC; obsCode = codeC; end
        endcase
        expPhase = (!mdl[d].synced || mdl[d].faulted) ? 3 : mdl[d].pos;
        checkOutput($sformatf("%s_%s_phase", curTag, dutName[d]), obsPhase, expPhase);
        checkOutput($sformatf("%s_%s_dwell", curTag, dutName[d]), obsDwell, mdl[d].run);
        checkOutput($sformatf("%s_%s_cycles", curTag, dutName[d]), obsCycle, mdl[d].cycles);
        checkOutput($sformatf("%s_%s_err", curTag, dutName[d]), obsErr, int'(mdl[d].faulted));
        checkOutput($sformatf("%s_%s_code", curTag, dutName[d]), obsCode, mdl[d].code);
    endtask

    task automatic applyStimulus(input logic [2:0] lt, input bit clr);
        light  = lt;
        clrErr = clr;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            mdl[d] = stepModel(mdl[d], lt, clr, minDwell[d], maxDwell[d], cntMax[d]);
        for (int d = 0; d < 3; d++) checkDut(d);
        clrErr = 1'b0;
    endtask

    // Asserted between edges so the check proves reset acts without a clock.
    task automatic doReset();
        reset = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) mdl[d] = freshModel();
        for (int d = 0; d < 3; d++) checkDut(d);
        checkOutput($sformatf("%s_rst_phaseA", curTag), phaseA, 3);
        checkOutput($sformatf("%s_rst_cycleA", curTag), cycleA, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] seq[3] = '{3'b100, 3'b001, 3'b010};
        int r;
        logic [2:0] lt;
        bit clr;

        reset  = 1'b1;
        light  = 3'b000;
        clrErr = 1'b0;
        for (int d = 0; d < 3; d++) mdl[d] = freshModel();
        @(posedge clk);
        #1;
        curTag = "reset";
        doReset();

        curTag = "fullCycle";
        applyStimulus(3'b100, 0);
        applyStimulus(3'b001, 0);
        applyStimulus(3'b010, 0);
        applyStimulus(3'b100, 0);
        checkOutput("fullCycle_errA", errA, 0);
        checkOutput("fullCycle_cycleA", cycleA, 1);
        checkOutput("fullCycle_phaseA", phaseA, 0);

        curTag = "skipGreen";
        applyStimulus(3'b010, 0);
        checkOutput("skipGreen_errA", errA, 1);
        checkOutput("skipGreen_codeA", codeA, 2);
        checkOutput("skipGreen_phaseA", phaseA, 3);

        curTag = "illegalCode";
        applyStimulus(3'b000, 1);
        applyStimulus(3'b100, 0);
        applyStimulus(3'b001, 0);
        applyStimulus(3'b110, 0);
        checkOutput("illegalCode_codeA", codeA, 1);
        applyStimulus(3'b001, 1);
        checkOutput("clear_errA", errA, 0);
        checkOutput("clear_phaseA", phaseA, 3);
        checkOutput("clear_cycleA", cycleA, 1);

        curTag = "dwellShort";
        doReset();
        applyStimulus(3'b100, 0);
        applyStimulus(3'b100, 0);
        applyStimulus(3'b001, 0);
        checkOutput("dwellShort_codeB", codeB, 3);

        curTag = "dwellLong";
        doReset();
        repeat (3) applyStimulus(3'b100, 0);
        repeat (4) applyStimulus(3'b001, 0);
        checkOutput("dwellLong4_errB", errB, 0);
        applyStimulus(3'b001, 0);
        checkOutput("dwellLong5_codeB", codeB, 4);

        curTag = "saturate";
        doReset();
        repeat (5) begin
            applyStimulus(3'b100, 0);
            applyStimulus(3'b001, 0);
            applyStimulus(3'b010, 0);
        end
        applyStimulus(3'b100, 0);
        checkOutput("saturate_cycleC", cycleC, 3);
        checkOutput("saturate_cycleA", cycleA, 5);
        applyStimulus(3'b001, 0);
        curTag = "midGreenReset";
        doReset();
        checkOutput("midGreenReset_cycleC", cycleC, 0);

        curTag = "clrWins";
        applyStimulus(3'b100, 0);
        applyStimulus(3'b111, 1);
        checkOutput("clrWins_errA", errA, 0);
        checkOutput("clrWins_phaseA", phaseA, 3);

        curTag = "random";
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 99);
            lt = mdl[0].synced ? seq[(mdl[0].pos + 1) % 3] : seq[0];
            if (r >= 55 && r < 80) lt = mdl[0].synced ? seq[mdl[0].pos] : seq[0];
            else if (r >= 80 && r < 92) lt = seq[$urandom_range(0, 2)];
            else if (r >= 92) lt = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 99) < (mdl[0].faulted ? 20 : 3));
            if ($urandom_range(0, 199) == 0) doReset();
            applyStimulus(lt, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
